par2ser: RTL and testbench
==========================

Name: par2ser

Overview:
- Parallel-to-serial converter that feeds the team's serial-to-parallel deserializer.
- Accepts W-bit words on a valid/ready handshake and emits them one bit per strobe on ser_dout/ser_dout_valid.
- Holds one shifting word plus one pending word, so back-to-back words serialize with no gap.
- ser_en paces the bit rate (tie high for one bit per clock, or drive from a baud tick).

Parameters:
W, 8, word width in bits; legal range W >= 2.
MSB_FIRST, 1, 1 = bit W-1 is sent first (matches a deserializer that shifts in at the LSB); 0 = bit 0 is sent first.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
par_din  input  W  parallel word in.
par_din_valid  input  1  par_din holds a word.
par_din_ready  output  1  block can accept a word this cycle.
ser_en  input  1  bit-advance enable from downstream pacing.
ser_dout  output  1  current serial bit.
ser_dout_valid  output  1  one-cycle strobe: ser_dout is a bit to consume this cycle.
ser_dout_last  output  1  high with ser_dout_valid on the final bit of a word.
busy  output  1  a word is shifting or pending.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Storage: shift register sh[W-1:0], bit counter cnt[$clog2(W)-1:0], pending register pend[W-1:0] with flag pend_full.
- FSM states: IDLE and SHIFT.
- Reset (rst=1 at clock edge):
  - state=IDLE, cnt=0, sh=0, pend_full=0.
  - Outputs: ser_dout=0, ser_dout_valid=0, ser_dout_last=0, busy=0.
  - par_din_ready=0 while rst is high.
- Reset mid-operation discards the in-flight word and the pending word. No further bits are emitted.
- par_din_ready = !rst && !pend_full. It is a function of registered state only; there is no combinational path from par_din_valid.
- accept = par_din_valid && par_din_ready.
- ser_dout_valid = (state==SHIFT) && ser_en.
- ser_dout = sh[W-1] if MSB_FIRST, else sh[0]. It is 0 in IDLE.
- ser_dout_last = ser_dout_valid && (cnt==W-1).
- busy = (state==SHIFT) || pend_full.
- IDLE:
  - On accept, load sh<=par_din, cnt<=0, and go to SHIFT.
  - The first bit is presented on the next cycle (latency 1 cycle from accept to first ser_dout_valid when ser_en=1).
- SHIFT, cycle with ser_en=0: hold sh and cnt; ser_dout stays stable.
- SHIFT, ser_en=1 and cnt<W-1: shift sh by one toward the output end (zero fill) and increment cnt.
- SHIFT, ser_en=1 and cnt==W-1 (word complete), priority order:
  1. If pend_full: sh<=pend, pend_full<=0, cnt<=0, stay in SHIFT.
  2. Else if accept: sh<=par_din, cnt<=0, stay in SHIFT.
  3. Else go to IDLE with cnt<=0.
  - Either of the first two cases gives a gapless stream.
- SHIFT, accept while not in the complete case: pend<=par_din and pend_full<=1.
- An accept can never coincide with pend_full=1, because ready is low then.
- The same-cycle "complete and accept" case bypasses pend; it must not also set pend_full.
- Throughput: one word per W enabled cycles. With ser_en=1 and valid held high, the line never idles.
- ser_en asserted in IDLE has no effect.
- Words are never dropped or duplicated. Bits are emitted in index order per MSB_FIRST.

Test Plan:
- Single word: W=8, MSB_FIRST=1, ser_en=1, par_din=8'hA5 accepted at cycle 0 -> ser_dout_valid high cycles 1-8 with bits 1,0,1,0,0,1,0,1; ser_dout_last only at cycle 8; busy low from cycle 9; ready stays 1.
- Back-to-back: 8'hA5 then 8'h3C with valid held, ser_en=1 -> 16 consecutive valid strobes, no gap; second word's bits 0,0,1,1,1,1,0,0; last at strobes 8 and 16.
- Backpressure: offer 8'h11, 8'h22, 8'h33 continuously -> 8'h22 goes to pend and ready drops to 0 after that accept. 8'h33 is held on the input and accepted as 8'h22 moves into the shifter. Output order is 11, 22, 33.
- Pacing: ser_en toggles 1,0,1,0..., word 8'hF0 -> exactly 8 valid strobes over 15 cycles; ser_dout stable during ser_en=0 cycles.
- LSB-first: MSB_FIRST=0, par_din=8'h01 -> first bit 1, then seven 0s.
- Reset mid-word: assert rst after 3 bits of 8'hFF with 8'hAA pending -> from the next edge valid=0, busy=0, ready=0 while rst is high. After release, 8'h5A is serialized cleanly.
- Loopback into the serial-to-parallel deserializer (W=8): random 1000-word stream reconstructed exactly, in order.

Source files
------------

// File: rtl/par2ser.sv
// Parallel-to-serial converter: accepts W-bit words on valid/ready and shifts them
// out one bit per ser_en strobe, with a one-word pending buffer for gapless streams.
module par2ser #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] par_din,
    input  logic         par_din_valid,
    output logic         par_din_ready,
    input  logic         ser_en,
    output logic         ser_dout,
    output logic         ser_dout_valid,
    output logic         ser_dout_last,
    output logic         busy
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [W-1:0]   sh_r, sh_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [W-1:0]   pend_r, pend_s;
    logic           pend_full_r, pend_full_s;
    logic           accept_s;
    logic           complete_s;

    // Move the shifter one bit toward the output end, zero filling behind.
    function automatic logic [W-1:0] shift_one(input logic [W-1:0] v);
        if (MSB_FIRST) begin
            shift_one = {v[W-2:0], 1'b0};
        end else begin
            shift_one = {1'b0, v[W-1:1]};
        end
    endfunction

    // Handshake and output decode; ready depends on registered state and rst only.
    always_comb begin
        par_din_ready  = !rst && !pend_full_r;
        accept_s       = par_din_valid && par_din_ready;
        ser_dout_valid = (state_r == SHIFT) && ser_en;
        complete_s     = ser_dout_valid && (cnt_r == CNT_LAST);
        ser_dout_last  = complete_s;
        busy           = (state_r == SHIFT) || pend_full_r;
        if (state_r == SHIFT) begin
            ser_dout = MSB_FIRST ? sh_r[W-1] : sh_r[0];
        end else begin
            ser_dout = 1'b0;
        end
    end

    // Next-state logic for FSM, shifter, bit counter and pending buffer.
    always_comb begin
        state_s     = state_r;
        sh_s        = sh_r;
        cnt_s       = cnt_r;
        pend_s      = pend_r;
        pend_full_s = pend_full_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    sh_s    = par_din;
                    cnt_s   = {CW{1'b0}};
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (complete_s) begin
                    cnt_s = {CW{1'b0}};
                    // A same-cycle accept bypasses pend and goes straight to the shifter.
                    if (pend_full_r) begin
                        sh_s        = pend_r;
                        pend_full_s = 1'b0;
                    end else if (accept_s) begin
                        sh_s = par_din;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    if (ser_en) begin
                        sh_s  = shift_one(sh_r);
                        cnt_s = cnt_r + CW'(1);
                    end else begin
                        sh_s = sh_r;
                    end
                    if (accept_s) begin
                        pend_s      = par_din;
                        pend_full_s = 1'b1;
                    end else begin
                        pend_full_s = pend_full_r;
                    end
                end
            end
            default: begin
                state_s     = IDLE;
                cnt_s       = {CW{1'b0}};
                pend_full_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sh_r        <= {W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            pend_r      <= {W{1'b0}};
            pend_full_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sh_r        <= sh_s;
            cnt_r       <= cnt_s;
            pend_r      <= pend_s;
            pend_full_r <= pend_full_s;
        end
    end

endmodule

// File: tb/tb_par2ser.sv
// Self-checking bench for par2ser: directed steps plus a word scoreboard fed by a
// behavioural deserializer that reassembles the serial stream.
module tb_par2ser;

    logic       clk;
    logic       rst;
    logic [7:0] par_din;
    logic       par_din_valid;
    logic       par_din_ready;
    logic       ser_en;
    logic       ser_dout;
    logic       ser_dout_valid;
    logic       ser_dout_last;
    logic       busy;

    logic [7:0] din_l;
    logic       valid_l;
    logic       ready_l;
    logic       dout_l;
    logic       dvalid_l;
    logic       last_l;
    logic       busy_l;

    par2ser #(.W(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .par_din(par_din), .par_din_valid(par_din_valid),
        .par_din_ready(par_din_ready), .ser_en(ser_en), .ser_dout(ser_dout),
        .ser_dout_valid(ser_dout_valid), .ser_dout_last(ser_dout_last), .busy(busy)
    );

    par2ser #(.W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .par_din(din_l), .par_din_valid(valid_l),
        .par_din_ready(ready_l), .ser_en(ser_en), .ser_dout(dout_l),
        .ser_dout_valid(dvalid_l), .ser_dout_last(last_l), .busy(busy_l)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         strobes  = 0;
    int         words_rx = 0;
    int         run_len  = 0;
    int         max_run  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Deserializer model: shift in at the LSB, compare each finished word with the scoreboard.
    initial begin
        int         bitn;
        logic [7:0] shw;
        bitn = 0;
        shw  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                bitn    = 0;
                run_len = 0;
            end else begin
                if (ser_dout_valid) begin
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    strobes++;
                    shw = {shw[6:0], ser_dout};
                    chk("last_pos", 32'(ser_dout_last), 32'(bitn == 7));
                    bitn++;
                    if (bitn == 8) begin
                        bitn = 0;
                        words_rx++;
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $error("FAIL unexpected_word: observed %0h expected none", shw);
                        end else begin
                            chk("word", 32'(shw), 32'(exp_q.pop_front()));
                        end
                    end
                end else begin
                    run_len = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send(input logic [7:0] w, output int waited);
        par_din       = w;
        par_din_valid = 1'b1;
        waited        = 0;
        @(negedge clk);
        while (!par_din_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        chk("send_ready", 32'(par_din_ready), 32'(1));
        if (par_din_ready) exp_q.push_back(w);
        @(posedge clk);
        #1;
        par_din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 400) begin
            k++;
            @(negedge clk);
        end
        chk("idle_timeout", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         wt;
        int         s0;
        int         rx0;
        logic [7:0] a5;
        logic       held;
        logic [7:0] w;

        rst           = 1'b1;
        par_din       = 8'h00;
        par_din_valid = 1'b0;
        ser_en        = 1'b1;
        din_l         = 8'h00;
        valid_l       = 1'b0;
        a5            = 8'hA5;
        held          = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", 32'(ser_dout_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(par_din_ready), 32'(0));
        chk("rst_dout", 32'(ser_dout), 32'(0));
        chk("rst_last", 32'(ser_dout_last), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(par_din_ready), 32'(1));
        @(posedge clk);
        #1;

        // Single word 8'hA5, per-cycle bit check
        send(a5, wt);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("single_valid", 32'(ser_dout_valid), 32'(1));
            chk("single_bit", 32'(ser_dout), 32'(a5[8-c]));
            chk("single_last", 32'(ser_dout_last), 32'(c == 8));
            chk("single_ready", 32'(par_din_ready), 32'(1));
        end
        @(negedge clk);
        chk("single_busy_end", 32'(busy), 32'(0));
        chk("single_valid_end", 32'(ser_dout_valid), 32'(0));
        @(posedge clk);
        #1;

        // Back-to-back, gapless
        max_run = 0;
        send(8'hA5, wt);
        send(8'h3C, wt);
        wait_idle();
        chk("b2b_run", 32'(max_run), 32'(16));

        // Backpressure through the pending register
        max_run = 0;
        send(8'h11, wt);
        send(8'h22, wt);
        send(8'h33, wt);
        chk("bp_wait", 32'(wt), 32'(7));
        wait_idle();
        chk("bp_run", 32'(max_run), 32'(24));

        // Pacing with ser_en toggling
        s0 = strobes;
        send(8'hF0, wt);
        for (int c = 1; c <= 15; c++) begin
            ser_en = (c % 2 == 1);
            @(negedge clk);
            if (!ser_en) begin
                chk("pace_novalid", 32'(ser_dout_valid), 32'(0));
                held = ser_dout;
            end else if (c > 1) begin
                chk("pace_stable", 32'(ser_dout), 32'(held));
            end
            @(posedge clk);
            #1;
        end
        ser_en = 1'b1;
        @(negedge clk);
        chk("pace_busy_end", 32'(busy), 32'(0));
        chk("pace_strobes", 32'(strobes - s0), 32'(8));
        @(posedge clk);
        #1;

        // LSB-first instance
        din_l   = 8'h01;
        valid_l = 1'b1;
        @(negedge clk);
        chk("lsb_ready", 32'(ready_l), 32'(1));
        @(posedge clk);
        #1;
        valid_l = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("lsb_valid", 32'(dvalid_l), 32'(1));
            chk("lsb_bit", 32'(dout_l), 32'(c == 1));
            chk("lsb_last", 32'(last_l), 32'(c == 8));
        end
        @(negedge clk);
        chk("lsb_busy_end", 32'(busy_l), 32'(0));
        @(posedge clk);
        #1;

        // Reset mid-word with a word pending
        send(8'hFF, wt);
        send(8'hAA, wt);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_ready_now", 32'(par_din_ready), 32'(0));
        s0 = strobes;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_valid", 32'(ser_dout_valid), 32'(0));
            chk("midrst_busy", 32'(busy), 32'(0));
            chk("midrst_ready", 32'(par_din_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h5A, wt);
        wait_idle();
        chk("midrst_after_q", 32'(exp_q.size()), 32'(0));

        // Random loopback stream
        rx0 = words_rx;
        for (int i = 0; i < 1000; i++) begin
            w = 8'($urandom());
            send(w, wt);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("loop_count", 32'(words_rx - rx0), 32'(1000));
        chk("loop_q_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
